external_io_fifo: RTL and testbench
===================================

Name: external_io_fifo

Overview:
- Next-generation host IO block for the shapool core. Loads job and device configuration over SPI0/SPI1 during a load phase, then runs the core.
- Buffers up to RESULT_DEPTH successful nonces in a FIFO instead of halting on the first success.
- Streams the buffered results out over SPI1, then passes SPI1 data through so devices can be daisy-chained.
- Sits between the board pins and the shapool core, at top level.

Parameters:
- DEVICE_CONFIG_WIDTH, 8: device_config bits (nonce_start).
- JOB_CONFIG_WIDTH, 360: job_config bits (sha_state + message_head + difficulty).
- RESULT_DATA_WIDTH, 32: result word bits (nonce).
- RESULT_DEPTH, 4: result FIFO entries, power of 2, ≥2.
- SYNC_STAGES, 2: synchroniser flops on sck/sdi, ≥2.

Ports:
- clk  in  1  reference clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  high = load phase (core held, shifting enabled).
- sck0  in  1  SPI0 clock (job config).
- sdi0  in  1  SPI0 data.
- cs0_n  in  1  SPI0 select, active low.
- sck1  in  1  SPI1 clock.
- sdi1  in  1  SPI1 data.
- sdo1  out  1  SPI1 data out.
- cs1_n  in  1  SPI1 select, active low.
- device_config  out  DEVICE_CONFIG_WIDTH  loaded device config.
- job_config  out  JOB_CONFIG_WIDTH  loaded job config.
- job_config_complete  out  1  at least JOB_CONFIG_WIDTH bits shifted since the last load entry.
- shapool_result  in  RESULT_DATA_WIDTH  candidate nonce.
- shapool_success  in  1  one-cycle success strobe.
- ready  out  1  FIFO non-empty (host interrupt).
- halt  out  1  core must stop.
- overflow  out  1  sticky: a success was dropped.
- result_count  out  clog2(RESULT_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values (synchronous, wins over everything):
  - state IDLE; all sync flops 0; device_config 0; job_config 0; shift register 0.
  - FIFO empty, result_count 0; bit counters 0.
  - ready 0; overflow 0; job_config_complete 0; halt 1.
- Synchronisers:
  - sck0, sck1, sdi0 and sdi1 each pass through SYNC_STAGES flops.
  - A rising edge is detected on an extra flop (old=0, new=1), using the last-stage sdi as data.
  - cs0_n and cs1_n are sampled directly.
- States: IDLE, EXEC, DRAIN_LOAD, DRAIN_SHIFT. Any state goes to IDLE when load=1; otherwise the transitions below apply.
- IDLE:
  - Qualified sck0 edge (cs0_n=0): job_config <= {job_config[W-2:0], sdi0}, msb-first; job bit counter increments, saturating at JOB_CONFIG_WIDTH.
  - Qualified sck1 edge (cs1_n=0): device_config shifts the same way.
  - On entry to IDLE: FIFO flushed, overflow cleared, job bit counter cleared.
  - load=0 goes to EXEC.
- EXEC:
  - shapool_success with FIFO not full: push shapool_result.
  - shapool_success with FIFO full: drop the result, set overflow.
  - cs1_n=0 goes to DRAIN_LOAD. A success in that same cycle is still pushed.
- DRAIN_LOAD (one cycle):
  - Shift register <= FIFO head and pop if FIFO non-empty, else 0.
  - Word bit counter cleared; next state DRAIN_SHIFT.
- DRAIN_SHIFT:
  - Qualified sck1 edge: shift register <= {sr[W-2:0], sdi1}; word counter increments.
  - On the edge that completes RESULT_DATA_WIDTH bits: counter wraps to 0. If the FIFO is non-empty, shift register <= head and pop, instead of the shift. Otherwise the shift proceeds (pure pass-through).
  - Upstream bits received while local words are being output are discarded; pass-through starts after the last local word.
  - Successes are ignored in both DRAIN states.
- sdo1: shift register MSB in DRAIN_LOAD/DRAIN_SHIFT, else device_config MSB.
- Outputs:
  - ready = (result_count != 0).
  - halt = (state != EXEC) or FIFO full.
  - job_config_complete = job bit counter == JOB_CONFIG_WIDTH.
- FIFO: circular pointers with wrap-around. Push and pop never occur in the same cycle, because pushes happen only in EXEC and pops only in DRAIN.

Test Plan:
- Reset, then load=1. Shift 360 bits of 0xA5-pattern on SPI0 and 8'h3C on SPI1 → job_config and device_config match; job_config_complete=1 after bit 360 and 0 after bit 359; sdo1 follows device_config MSB.
- load=0. Pulse success with 0x11111111, then 0x22222222 → ready=1, result_count=2, halt=0. Then cs1_n=0 and 64 sck1 edges with sdi1=1 → sdo1 emits 0x11111111 then 0x22222222. The next 32 edges emit all 1s (pass-through).
- Five successes with RESULT_DEPTH=4 → halt=1 after the 4th, overflow=1 after the 5th; drained words equal the first four values.
- cs1_n asserted in EXEC with an empty FIFO → first word out is 0x00000000, then sdi1 pass-through with 32-bit delay.
- success and cs1_n in the same cycle → the value is drained first. load=1 mid-drain → IDLE next cycle; ready=0, overflow=0 after entry.
- reset asserted in DRAIN_SHIFT and in EXEC → all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/external_io_fifo.sv
// external_io_fifo
// Host IO block sitting between the board pins and the shapool core.
// During the load phase the job and device configuration are shifted in
// over SPI0 / SPI1. In EXEC the core runs and every success is buffered in a
// small result FIFO. When the host selects SPI1 the buffered results are
// shifted out on sdo1, after which SPI1 data passes straight through so that
// several devices can be daisy-chained.
//
// Ports
//   clk, reset            reference clock, synchronous active-high reset
//   load                  high = load phase (core held, config shifting)
//   sck0, sdi0, cs0_n     SPI0, job configuration
//   sck1, sdi1, cs1_n     SPI1, device configuration / result drain
//   sdo1                  SPI1 data out
//   device_config         loaded device configuration (nonce_start)
//   job_config            loaded job configuration
//   job_config_complete   a full job word has been shifted since load entry
//   shapool_result        candidate nonce from the core
//   shapool_success       one-cycle success strobe from the core
//   ready                 result FIFO non-empty (host interrupt)
//   halt                  core must stop
//   overflow              sticky, a success was dropped on a full FIFO
//   result_count          FIFO occupancy
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | load phase, SPI0/SPI1 shift job/device configuration
// EXEC        | core running, successes pushed into the result FIFO
// DRAIN_LOAD  | one cycle, FIFO head (or zero) copied into shift register
// DRAIN_SHIFT | results shifted out on sdo1, then SPI1 pass-through
module external_io_fifo #(
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int JOB_CONFIG_WIDTH    = 360,
  parameter int RESULT_DATA_WIDTH   = 32,
  parameter int RESULT_DEPTH        = 4,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                sck0,
  input  logic                                sdi0,
  input  logic                                cs0_n,
  input  logic                                sck1,
  input  logic                                sdi1,
  output logic                                sdo1,
  input  logic                                cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0]      device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]         job_config,
  output logic                                job_config_complete,
  input  logic [RESULT_DATA_WIDTH-1:0]        shapool_result,
  input  logic                                shapool_success,
  output logic                                ready,
  output logic                                halt,
  output logic                                overflow,
  output logic [$clog2(RESULT_DEPTH):0]       result_count
);

  localparam int PTR_W  = $clog2(RESULT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int JCNT_W = $clog2(JOB_CONFIG_WIDTH + 1);
  localparam int WCNT_W = (RESULT_DATA_WIDTH > 1) ? $clog2(RESULT_DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(RESULT_DEPTH);
  localparam logic [JCNT_W-1:0] JCNT_MAX      = JCNT_W'(JOB_CONFIG_WIDTH);
  localparam logic [WCNT_W-1:0] WORD_LAST     = WCNT_W'(RESULT_DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EXEC        = 2'd1,
    DRAIN_LOAD  = 2'd2,
    DRAIN_SHIFT = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sck0_sync;
  logic [SYNC_STAGES-1:0] sdi0_sync;
  logic [SYNC_STAGES-1:0] sck1_sync;
  logic [SYNC_STAGES-1:0] sdi1_sync;
  logic                   sck0_old;
  logic                   sck1_old;
  logic                   sdi0_s;
  logic                   sdi1_s;
  logic                   sck0_edge;
  logic                   sck1_edge;

  // result FIFO
  logic [RESULT_DATA_WIDTH-1:0] fifo_mem [RESULT_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [RESULT_DATA_WIDTH-1:0] fifo_head;

  // drain shifter and config counters
  logic [RESULT_DATA_WIDTH-1:0] shift_reg;
  logic [WCNT_W-1:0]            word_cnt;
  logic [JCNT_W-1:0]            job_cnt;
  logic                         word_last;

  // control strobes from the FSM
  logic enter_idle;
  logic push;
  logic drop;
  logic drain_load;
  logic drain_shift;
  logic pop;
  logic cfg_shift_en;

  assign sdi0_s    = sdi0_sync[SYNC_STAGES-1];
  assign sdi1_s    = sdi1_sync[SYNC_STAGES-1];
  // chip selects are qualifiers only, taken straight from the pins
  assign sck0_edge = sck0_sync[SYNC_STAGES-1] & ~sck0_old & ~cs0_n;
  assign sck1_edge = sck1_sync[SYNC_STAGES-1] & ~sck1_old & ~cs1_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck0_sync <= '0;
      sdi0_sync <= '0;
      sck1_sync <= '0;
      sdi1_sync <= '0;
      sck0_old  <= 1'b0;
      sck1_old  <= 1'b0;
    end else begin
      sck0_sync <= {sck0_sync[SYNC_STAGES-2:0], sck0};
      sdi0_sync <= {sdi0_sync[SYNC_STAGES-2:0], sdi0};
      sck1_sync <= {sck1_sync[SYNC_STAGES-2:0], sck1};
      sdi1_sync <= {sdi1_sync[SYNC_STAGES-2:0], sdi1};
      sck0_old  <= sck0_sync[SYNC_STAGES-1];
      sck1_old  <= sck1_sync[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    enter_idle  = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    drain_load  = 1'b0;
    drain_shift = 1'b0;
    if (load) begin
      // load overrides everything; flush only on an actual transition into IDLE
      state_next = IDLE;
      enter_idle = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          state_next = EXEC;
        end
        EXEC: begin
          push = shapool_success & ~fifo_full;
          drop = shapool_success & fifo_full;
          if (!cs1_n) begin
            state_next = DRAIN_LOAD;
          end
        end
        DRAIN_LOAD: begin
          drain_load = 1'b1;
          state_next = DRAIN_SHIFT;
        end
        DRAIN_SHIFT: begin
          drain_shift = sck1_edge;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign cfg_shift_en = (state == IDLE);
  assign word_last    = (word_cnt == WORD_LAST);
  assign pop          = (drain_load | (drain_shift & word_last)) & ~fifo_empty;

  // ---------------------------------------------------------------- FIFO
  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // push only in EXEC, pop only in DRAIN, so the two never coincide
  always_ff @(posedge clk) begin
    if (reset || enter_idle) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        fifo_count <= fifo_count + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fifo_count <= fifo_count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= shapool_result;
    end
  end

  // ---------------------------------------------------------------- config
  always_ff @(posedge clk) begin
    if (reset) begin
      job_config    <= '0;
      device_config <= '0;
      job_cnt       <= '0;
    end else begin
      if (cfg_shift_en && sck0_edge) begin
        job_config <= {job_config[JOB_CONFIG_WIDTH-2:0], sdi0_s};
        if (job_cnt != JCNT_MAX) begin
          job_cnt <= job_cnt + 1'b1;
        end
      end
      if (cfg_shift_en && sck1_edge) begin
        device_config <= {device_config[DEVICE_CONFIG_WIDTH-2:0], sdi1_s};
      end
      if (enter_idle) begin
        job_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- drain
  // While local words remain, each word boundary reloads the shifter and the
  // upstream bits collected during that word are lost. After the last local
  // word the shifter just keeps shifting, giving a 32-bit-delayed pass-through.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      word_cnt  <= '0;
    end else if (drain_load) begin
      shift_reg <= fifo_empty ? '0 : fifo_head;
      word_cnt  <= '0;
    end else if (drain_shift) begin
      if (word_last) begin
        word_cnt <= '0;
        if (!fifo_empty) begin
          shift_reg <= fifo_head;
        end else begin
          shift_reg <= {shift_reg[RESULT_DATA_WIDTH-2:0], sdi1_s};
        end
      end else begin
        shift_reg <= {shift_reg[RESULT_DATA_WIDTH-2:0], sdi1_s};
        word_cnt  <= word_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign sdo1 = ((state == DRAIN_LOAD) || (state == DRAIN_SHIFT))
                ? shift_reg[RESULT_DATA_WIDTH-1]
                : device_config[DEVICE_CONFIG_WIDTH-1];

  assign ready               = (fifo_count != '0);
  assign halt                = (state != EXEC) | fifo_full;
  assign job_config_complete = (job_cnt == JCNT_MAX);
  assign result_count        = fifo_count;

endmodule

// File: tb/tb_external_io_fifo.sv
// Self-checking bench for external_io_fifo. A queue-based model holds the
// buffered results; the drained SPI1 stream is predicted as "local words
// (or one zero word), then sdi1 delayed by one word".
module tb_external_io_fifo;

  localparam int DW = 8;
  localparam int JW = 360;
  localparam int RW = 32;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic          sck0, sdi0, cs0_n;
  logic          sck1, sdi1, cs1_n;
  logic          sdo1;
  logic [DW-1:0] device_config;
  logic [JW-1:0] job_config;
  logic          job_config_complete;
  logic [RW-1:0] shapool_result;
  logic          shapool_success;
  logic          ready, halt, overflow;
  logic [2:0]    result_count;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] fifo_q[$];
  logic          exp_ovf;
  logic [JW-1:0] exp_job;
  logic [DW-1:0] exp_dev;
  int            exp_jcnt;
  logic          sdi_hist [0:1023];

  external_io_fifo #(
    .DEVICE_CONFIG_WIDTH(DW),
    .JOB_CONFIG_WIDTH(JW),
    .RESULT_DATA_WIDTH(RW),
    .RESULT_DEPTH(RD),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .sck0(sck0),
    .sdi0(sdi0),
    .cs0_n(cs0_n),
    .sck1(sck1),
    .sdi1(sdi1),
    .sdo1(sdo1),
    .cs1_n(cs1_n),
    .device_config(device_config),
    .job_config(job_config),
    .job_config_complete(job_config_complete),
    .shapool_result(shapool_result),
    .shapool_success(shapool_success),
    .ready(ready),
    .halt(halt),
    .overflow(overflow),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_fifo(input string tag, input logic in_exec);
    chk({tag, ".ready"}, 384'(ready), 384'(fifo_q.size() != 0));
    chk({tag, ".count"}, 384'(result_count), 384'(fifo_q.size()));
    chk({tag, ".overflow"}, 384'(overflow), 384'(exp_ovf));
    chk({tag, ".halt"}, 384'(halt), 384'(!in_exec || fifo_q.size() == RD));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, 384'(ready), 384'(0));
    chk({tag, ".halt"}, 384'(halt), 384'(1));
    chk({tag, ".overflow"}, 384'(overflow), 384'(0));
    chk({tag, ".complete"}, 384'(job_config_complete), 384'(0));
    chk({tag, ".count"}, 384'(result_count), 384'(0));
    chk({tag, ".dev"}, 384'(device_config), 384'(0));
    chk({tag, ".job"}, 384'(job_config), 384'(0));
    chk({tag, ".sdo1"}, 384'(sdo1), 384'(0));
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_ovf  = 1'b0;
    exp_job  = '0;
    exp_dev  = '0;
    exp_jcnt = 0;
  endtask

  task automatic sck0_bit(input logic b, input logic cs);
    @(negedge clk);
    sdi0  = b;
    cs0_n = cs;
    repeat (3) @(negedge clk);
    sck0 = 1'b1;
    repeat (4) @(negedge clk);
    sck0 = 1'b0;
    repeat (3) @(negedge clk);
    cs0_n = 1'b1;
    if (!cs) begin
      exp_job = {exp_job[JW-2:0], b};
      if (exp_jcnt < JW) exp_jcnt++;
    end
  endtask

  task automatic sck1_bit(input logic b, output logic dout);
    @(negedge clk);
    sdi1 = b;
    repeat (3) @(negedge clk);
    dout = sdo1;
    sck1 = 1'b1;
    repeat (4) @(negedge clk);
    sck1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_success(input logic [RW-1:0] v, input logic in_exec);
    @(negedge clk);
    shapool_result  = v;
    shapool_success = 1'b1;
    @(negedge clk);
    shapool_success = 1'b0;
    if (in_exec) begin
      if (fifo_q.size() < RD) fifo_q.push_back(v);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic enter_exec();
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    fifo_q.delete();
    exp_ovf  = 1'b0;
    exp_jcnt = 0;
  endtask

  // sdi_mode 1 drives all ones, otherwise random sdi1
  task automatic drain(input int n_edges, input int sdi_mode, input logic with_succ,
                       input logic [RW-1:0] sval);
    logic [RW-1:0] wq[$];
    logic [RW-1:0] got;
    logic [RW-1:0] expw;
    logic [RW-1:0] w;
    logic          dout;
    logic          b;
    logic          eb;
    int            npop;
    @(negedge clk);
    cs1_n = 1'b0;
    if (with_succ) begin
      shapool_result  = sval;
      shapool_success = 1'b1;
      if (fifo_q.size() < RD) fifo_q.push_back(sval);
      else exp_ovf = 1'b1;
    end
    @(negedge clk);
    shapool_success = 1'b0;
    @(negedge clk);
    wq = fifo_q;
    if (wq.size() == 0) wq.push_back('0);
    got  = '0;
    expw = '0;
    for (int k = 0; k < n_edges; k++) begin
      b = (sdi_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      sdi_hist[k] = b;
      sck1_bit(b, dout);
      if (k / RW < wq.size()) begin
        w  = wq[k / RW];
        eb = w[RW - 1 - (k % RW)];
      end else begin
        eb = sdi_hist[k - RW];
      end
      got  = {got[RW-2:0], dout};
      expw = {expw[RW-2:0], eb};
      if (k % RW == RW - 1) chk($sformatf("drain_word%0d", k / RW), 384'(got), 384'(expw));
    end
    npop = 1 + n_edges / RW;
    if (npop > fifo_q.size()) npop = fifo_q.size();
    repeat (npop) void'(fifo_q.pop_front());
    @(negedge clk);
    cs1_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    pat;
    logic [7:0]    dev;
    logic [JW-1:0] a5_const;
    logic [JW-1:0] job_hold;
    logic          dout;
    logic [RW-1:0] v;

    reset = 1'b1; load = 1'b1;
    sck0 = 1'b0; sdi0 = 1'b0; cs0_n = 1'b1;
    sck1 = 1'b0; sdi1 = 1'b0; cs1_n = 1'b1;
    shapool_success = 1'b0; shapool_result = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("reset0");
    reset = 1'b0;
    @(negedge clk);

    // job configuration, 0xA5 pattern msb first
    pat = 8'hA5;
    a5_const = {45{8'hA5}};
    for (int i = 0; i < JW; i++) begin
      sck0_bit(pat[7 - (i % 8)], 1'b0);
      if (i == JW - 2) chk("complete_359", 384'(job_config_complete), 384'(0));
      if (i == JW - 1) chk("complete_360", 384'(job_config_complete), 384'(1));
    end
    chk("job_a5", 384'(job_config), 384'(a5_const));
    for (int i = 0; i < 3; i++) sck0_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("job_extra", 384'(job_config), 384'(exp_job));
    chk("complete_sat", 384'(job_config_complete), 384'(exp_jcnt == JW));
    job_hold = exp_job;
    sck0_bit(~exp_job[0], 1'b1);
    chk("job_cs_high", 384'(job_config), 384'(job_hold));

    // device configuration
    dev = 8'h3C;
    cs1_n = 1'b0;
    for (int i = 0; i < DW; i++) begin
      sck1_bit(dev[7 - i], dout);
      exp_dev = {exp_dev[DW-2:0], dev[7 - i]};
      chk($sformatf("sdo1_idle%0d", i), 384'(sdo1), 384'(exp_dev[DW-1]));
    end
    cs1_n = 1'b1;
    chk("dev_3c", 384'(device_config), 384'(8'h3C));

    // two results, drain with sdi1=1
    enter_exec();
    chk_fifo("exec0", 1'b1);
    pulse_success(32'h11111111, 1'b1);
    pulse_success(32'h22222222, 1'b1);
    chk_fifo("two", 1'b1);
    drain(96, 1, 1'b0, '0);
    chk_fifo("drain2", 1'b0);
    go_idle();
    chk_fifo("idle1", 1'b0);

    // overflow with five random successes
    enter_exec();
    for (int i = 0; i < 5; i++) begin
      v = $urandom();
      pulse_success(v, 1'b1);
      chk_fifo($sformatf("succ%0d", i), 1'b1);
    end
    drain(160, 0, 1'b0, '0);
    chk_fifo("drain_ovf", 1'b0);
    go_idle();
    chk_fifo("idle2", 1'b0);
    chk("complete_cleared", 384'(job_config_complete), 384'(0));

    // empty FIFO drain
    enter_exec();
    drain(96, 0, 1'b0, '0);
    go_idle();

    // success and cs1_n in the same cycle
    enter_exec();
    drain(32, 0, 1'b1, $urandom());
    chk_fifo("same_cycle", 1'b0);
    go_idle();

    // load mid-drain with overflow set
    enter_exec();
    for (int i = 0; i < 5; i++) pulse_success($urandom(), 1'b1);
    drain(40, 0, 1'b0, '0);
    chk_fifo("mid_drain", 1'b0);
    pulse_success($urandom(), 1'b0);
    chk_fifo("succ_ignored", 1'b0);
    go_idle();
    chk_fifo("load_mid", 1'b0);

    // reset while in DRAIN_SHIFT
    enter_exec();
    pulse_success($urandom(), 1'b1);
    @(negedge clk);
    cs1_n = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("rst_drain");
    model_reset();
    cs1_n = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset while in EXEC
    pulse_success($urandom(), 1'b1);
    chk_fifo("pre_rst_exec", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("rst_exec");
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
